s27_bank: RTL
=============

// Module: s27_bank
// PURPOSE
//  Parametrised multi-channel successor of the s27 sequential benchmark core.
//  CHANNELS independent 3-flop s27 state machines share one clock, sync reset and a global enable.
//  Adds a saturating per-channel hit counter and an aggregate flag.
//  Serves as a scalable sequential benchmark for place/route runs.
// PARAMETERS
//  CHANNELS  4  number of independent s27 channels (>=1)
//  CNT_W     8  width of each per-channel hit counter (>=2)
// PORTS
//  clock    in   1               sole clock, rising edge
//  reset    in   1               synchronous, active-high; clears all state
//  en       in   1               global advance enable; 0 = hold all flops
//  cnt_clr  in   1               synchronous clear of all hit counters
//  g0       in   CHANNELS        per-channel input G0
//  g1       in   CHANNELS        per-channel input G1
//  g2       in   CHANNELS        per-channel input G2
//  g3       in   CHANNELS        per-channel input G3
//  g17      out  CHANNELS        per-channel output G17 (combinational)
//  hit_cnt  out  CHANNELS*CNT_W  packed counters; channel i at [i*CNT_W +: CNT_W]
//  any_hit  out  1               registered OR of this cycle's hits (hit = ~g17 & en)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Per channel i, state s5, s6, s7 (flops). Combinational terms:
//      n1 = g1|s7;  n3 = (s6 & ~g0) | (~n1 & g3);  n16 = n3 & ~s5;  g17 = ~n16
//  - Next state when en=1: s5 <= g0 & g17;  s6 <= n16;  s7 <= n1 & ~g2.
//  - When en=0, all state flops hold.
//  - g17 has zero latency from inputs and state; there is no output register.
//  - hit_i = en & n16.
//      If hit_i=1 and hit_cnt_i < 2^CNT_W-1, the counter increments by 1.
//      At all-ones it saturates and holds; it never wraps.
//  - cnt_clr=1 zeroes every counter next edge; wins over simultaneous hit; ignores en.
//  - any_hit <= |hit (registered, 1-cycle latency).
//      any_hit updates every cycle, including en=0, when it takes 0.
//  - Reset (priority over cnt_clr, en, scan):
//      s5 = s6 = s7 = 0, hit_cnt = 0, any_hit = 0.
//      Post-reset g17_i = g1_i | ~g3_i.
//      Reset mid-operation discards all state and counts at that edge.
//  - Channels never interact, except through any_hit and the scan chain.
// CONFIGURATION
//  - Macro S27_BANK_SCAN_CHAIN_EN: when defined, adds three ports:
//      scan_en  in  1 : shift mode select
//      scan_in  in  1 : serial chain input
//      scan_out out 1 : serial chain output
//  - scan_en=1 turns all state flops into one shift chain, shifting one position per edge regardless of en:
//      scan_in -> ch0.s5 -> ch0.s6 -> ch0.s7 -> ch1.s5 -> ... -> ch(N-1).s7 -> scan_out
//    scan_out equals ch(N-1).s7 directly, with no extra flop.
//    In shift mode counters hold (cnt_clr still honoured) and any_hit <= 0.
//  - Without the macro, the scan ports do not exist and behaviour is exactly as above.
// TESTING
//  1. Reset, then CHANNELS=4, g1=0, g3=1 all channels, en=0:
//     -> g17=4'b0000, counters stay 0, any_hit=0.
//  2. Reset, en=1, ch0 g0=0, g1=0, g2=0, g3=1:
//     -> g17[0]=0 at cycle 0; after 1 edge s6=1 and hit_cnt0=1; any_hit=1 one cycle after the first hit.
//  3. CNT_W=2, hold ch0 in a hit every cycle for 5 edges
//     -> hit_cnt0 = 1, 2, 3, 3, 3 (saturates, no wrap).
//  4. Assert cnt_clr in the same cycle as a hit
//     -> all counters 0 next edge; the increment is lost.
//  5. Assert reset while counters are nonzero and en=1
//     -> next edge: all state, counters and any_hit are 0; g17 = g1 | ~g3.
//  6. (S27_BANK_SCAN_CHAIN_EN, CHANNELS=2) scan_en=1, shift 101101 LSB-first:
//     -> after 6 edges chain holds the pattern; the next 6 edges replay it on scan_out; counters unchanged.

Source files
------------

// File: rtl/s27_bank.sv
// Bank of independent s27 sequential cores with saturating per-channel hit counters and a registered any-hit flag.
// Optional scan chain through all state flops when S27_BANK_SCAN_CHAIN_EN is defined.
module s27_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      cnt_clr,
  input  logic [CHANNELS-1:0]       g0,
  input  logic [CHANNELS-1:0]       g1,
  input  logic [CHANNELS-1:0]       g2,
  input  logic [CHANNELS-1:0]       g3,
  output logic [CHANNELS-1:0]       g17,
  output logic [CHANNELS*CNT_W-1:0] hit_cnt,
  output logic                      any_hit
`ifdef S27_BANK_SCAN_CHAIN_EN
  ,
  input  logic                      scan_en,
  input  logic                      scan_in,
  output logic                      scan_out
`endif
);

  logic                shift;
  logic [CHANNELS-1:0] s7_vec;
  logic [CHANNELS-1:0] hit;
  logic                any_hit_q;
  logic                any_hit_d;

`ifdef S27_BANK_SCAN_CHAIN_EN
  assign shift    = scan_en;
  assign scan_out = s7_vec[CHANNELS-1];
`else
  assign shift    = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             s5_q, s6_q, s7_q;
      logic             s5_d, s6_d, s7_d;
      logic             n1, n3, n16;
      logic             chain_bit;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Serial input of this channel's segment of the scan chain.
`ifdef S27_BANK_SCAN_CHAIN_EN
      if (gi == 0) begin : g_head
        assign chain_bit = scan_in;
      end else begin : g_link
        assign chain_bit = s7_vec[gi-1];
      end
`else
      assign chain_bit = 1'b0;
`endif

      assign n1      = g1[gi] | s7_q;
      assign n3      = (s6_q & ~g0[gi]) | (~n1 & g3[gi]);
      assign n16     = n3 & ~s5_q;
      assign g17[gi] = ~n16;
      assign hit[gi] = en & n16 & ~shift;
      assign s7_vec[gi] = s7_q;

      always_comb begin
        s5_d = s5_q;
        s6_d = s6_q;
        s7_d = s7_q;
        if (shift) begin
          s5_d = chain_bit;
          s6_d = s5_q;
          s7_d = s6_q;
        end else if (en) begin
          s5_d = g0[gi] & ~n16;
          s6_d = n16;
          s7_d = n1 & ~g2[gi];
        end
      end

      // Clear beats a simultaneous hit; all-ones holds instead of wrapping.
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
          cnt_d = '0;
        end else if (hit[gi] && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          s5_q  <= 1'b0;
          s6_q  <= 1'b0;
          s7_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          s5_q  <= s5_d;
          s6_q  <= s6_d;
          s7_q  <= s7_d;
          cnt_q <= cnt_d;
        end
      end

      assign hit_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

  assign any_hit_d = |hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      any_hit_q <= 1'b0;
    end else begin
      any_hit_q <= any_hit_d;
    end
  end

  assign any_hit = any_hit_q;

endmodule
